// File: rtl/cacheline_burst_arbiter.sv
// Cache-line burst arbiter: muxes icache/dcache line misses onto one
// 64-bit burst memory port, splitting writebacks into beats and
// reassembling read beats into a full line. All outputs registered.
module cacheline_burst_arbiter #(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_read,
  input  logic [ADDR_W-1:0]  i_addr,
  output logic [LINE_W-1:0]  i_rdata,
  output logic               i_resp,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [LINE_W-1:0]  d_wdata,
  output logic [LINE_W-1:0]  d_rdata,
  output logic               d_resp,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic [ADDR_W-1:0]  pmem_address,
  output logic [BURST_W-1:0] pmem_wdata,
  input  logic [BURST_W-1:0] pmem_rdata,
  input  logic               pmem_resp
);

  localparam int unsigned BEATS = LINE_W / BURST_W;
  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LINE_W-1:0]  wline_q, wline_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [LINE_W-1:0]  i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0]  d_rdata_q, d_rdata_d;
  logic [BURST_W-1:0] wdata_q, wdata_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic               i_resp_q, i_resp_d;
  logic               d_resp_q, d_resp_d;

  // Next-state, beat capture and registered-output computation
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wline_d   = wline_q;
    line_d    = line_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    i_resp_d  = 1'b0;
    d_resp_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (d_write) begin
          state_d = D_WR;
          wr_d    = 1'b1;
          addr_d  = d_addr & LINE_MASK;
          wline_d = d_wdata;
        end else if (d_read) begin
          state_d = D_RD;
          rd_d    = 1'b1;
          addr_d  = d_addr & LINE_MASK;
        end else if (i_read) begin
          state_d = I_RD;
          rd_d    = 1'b1;
          addr_d  = i_addr & LINE_MASK;
        end
      end
      I_RD, D_RD: begin
        if (pmem_resp) begin
          line_d[BURST_W*cnt_q +: BURST_W] = pmem_rdata;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            // Completed line goes straight to the output register so it
            // is valid in the same cycle the resp pulse is high.
            state_d = DONE;
            rd_d    = 1'b0;
            if (state_q == I_RD) begin
              i_rdata_d = line_d;
              i_resp_d  = 1'b1;
            end else begin
              d_rdata_d = line_d;
              d_resp_d  = 1'b1;
            end
          end
        end
      end
      D_WR: begin
        if (pmem_resp) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d  = DONE;
            wr_d     = 1'b0;
            d_resp_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Write beat tracks the counter so the next beat is presented right
    // after the previous one is accepted.
    wdata_d = wline_d[BURST_W*cnt_d +: BURST_W];
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wline_q   <= '0;
      line_q    <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wline_q   <= wline_d;
      line_q    <= line_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      i_resp_q  <= i_resp_d;
      d_resp_q  <= d_resp_d;
    end
  end

  assign i_rdata      = i_rdata_q;
  assign i_resp       = i_resp_q;
  assign d_rdata      = d_rdata_q;
  assign d_resp       = d_resp_q;
  assign pmem_read    = rd_q;
  assign pmem_write   = wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

endmodule
